inv_key_schedule: RTL

//  AES-128 round-key generator that sits directly upstream of the inverse-round datapath, on its key input.
//  - Expands a 128-bit cipher key into 11 round keys, one per cycle, into an internal register bank.
//  - Streams the round keys out in decryption order (rk10, rk9 ... rk0) over a valid/ready handshake.
//  - Round keys are plain FIPS-197 round keys; no InvMixColumns pre-transform is applied.

---
 rtl/inv_key_schedule.sv | 119 +++++++++++
 1 files changed

// File: rtl/inv_key_schedule.sv
// AES-128 key expander feeding the inverse-round datapath: builds all 11 round keys
// into a register bank, then streams them rk10..rk0 over a valid/ready handshake.
module inv_key_schedule #(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  input  logic             rk_restart,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_out,
  output logic             rk_valid,
  output logic [3:0]       rk_idx,
  output logic             rk_last,
  output logic             busy,
  output logic             keys_ready
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t           r_state;
  logic [3:0]       r_rcnt;
  logic [3:0]       r_rd_ptr;
  logic [KEY_W-1:0] r_bank [0:NR];

  logic [KEY_W-1:0] w_prev;
  logic [31:0]      w_rot;
  logic [31:0]      w_t;
  logic [31:0]      w_n0, w_n1, w_n2, w_n3;
  logic             w_hs;

  assign w_prev = r_bank[r_rcnt - 4'd1];
  assign w_rot  = {w_prev[23:0], w_prev[31:24]};
  assign w_t    = {sbox(w_rot[31:24]) ^ rcon(r_rcnt), sbox(w_rot[23:16]),
                   sbox(w_rot[15:8]), sbox(w_rot[7:0])};
  assign w_n0   = w_prev[127:96] ^ w_t;
  assign w_n1   = w_prev[95:64]  ^ w_n0;
  assign w_n2   = w_prev[63:32]  ^ w_n1;
  assign w_n3   = w_prev[31:0]   ^ w_n2;

  assign w_hs   = (r_state == S_READY) && rk_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (key_load)
        r_bank[0] <= key_in;
      else if (r_state == S_EXPAND)
        r_bank[r_rcnt] <= {w_n0, w_n1, w_n2, w_n3};
    end
  end

  // key_load and rk_restart both park the pointer at rk10, which also covers a
  // handshake in the same cycle (the transfer completes, the pointer is not decremented).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rcnt   <= 4'd1;
      r_rd_ptr <= LAST;
    end else if (key_load) begin
      r_state  <= S_EXPAND;
      r_rcnt   <= 4'd1;
      r_rd_ptr <= LAST;
    end else begin
      if (r_state == S_EXPAND) begin
        r_rcnt <= r_rcnt + 4'd1;
        if (r_rcnt == LAST)
          r_state <= S_READY;
      end
      if (rk_restart || (r_state == S_EXPAND && r_rcnt == LAST))
        r_rd_ptr <= LAST;
      else if (w_hs)
        r_rd_ptr <= (r_rd_ptr == 4'd0) ? LAST : r_rd_ptr - 4'd1;
    end
  end

  assign busy       = (r_state == S_EXPAND);
  assign keys_ready = (r_state == S_READY);
  assign rk_valid   = (r_state == S_READY);
  assign rk_idx     = r_rd_ptr;
  assign rk_last    = rk_valid && (r_rd_ptr == 4'd0);
  assign rk_out     = rk_valid ? r_bank[r_rd_ptr] : '0;

endmodule
